// File: rtl/gf_serial_mul.sv
`default_nettype none
// ============================================================================
// Module   : gf_serial_mul
// Brief    : Digit-serial GF(2^WIDTH) multiplier (Horner, MSB digit first)
//            with valid/ready handshakes and optional multiply-accumulate.
// Revision : 1.0 - initial release
// ============================================================================
module gf_serial_mul #(
    parameter int             WIDTH = 8,
    parameter logic [WIDTH:0] POLY  = 9'h11B,
    parameter int             DIGIT = 1
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_start_valid,
    output logic             out_start_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc_en,
    output logic             out_result_valid,
    input  logic             in_result_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("gf_serial_mul: WIDTH must be in 2..16");
        end
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("gf_serial_mul: WIDTH must be a multiple of DIGIT");
        end
        if (POLY[WIDTH] != 1'b1) begin : g_bad_poly
            $error("gf_serial_mul: POLY bit WIDTH must be set");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic            acc_en_reg;
    logic            accept;
    logic            last_digit;

    assign out_start_ready = !in_reset && ((state == IDLE) || ((state == DONE) && in_result_ready));
    assign accept          = in_start_valid && out_start_ready;
    assign last_digit      = (cnt == CW'(1));

    // One Horner step per bit of the digit: multiply by x, reduce, add a if the bit is set.
    always_comb begin
        acc_next = acc;
        for (int j = DIGIT - 1; j >= 0; j--) begin
            acc_next = {acc_next[WIDTH-2:0], 1'b0}
                     ^ (acc_next[WIDTH-1] ? POLY[WIDTH-1:0] : '0)
                     ^ (b_reg[WIDTH-DIGIT+j] ? a_reg : '0);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (last_digit) state_next = DONE;
            DONE: begin
                if (accept)               state_next = BUSY;
                else if (in_result_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state            <= IDLE;
            cnt              <= '0;
            acc              <= '0;
            a_reg            <= '0;
            b_reg            <= '0;
            acc_en_reg       <= 1'b0;
            out_result       <= '0;
            out_result_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_reg            <= in_a;
                b_reg            <= in_b;
                acc_en_reg       <= in_acc_en;
                acc              <= '0;
                cnt              <= CW'(STEPS);
                out_result_valid <= 1'b0;
            end else if (state == BUSY) begin
                acc   <= acc_next;
                b_reg <= b_reg << DIGIT;
                cnt   <= cnt - CW'(1);
                if (last_digit) begin
                    // out_result doubles as the accumulation source for the next MAC.
                    out_result       <= acc_next ^ (acc_en_reg ? out_result : '0);
                    out_result_valid <= 1'b1;
                end
            end else if (state == DONE && in_result_ready) begin
                out_result_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gf_serial_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf_serial_mul
// Brief    : Directed + randomised self-checking bench for gf_serial_mul.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf_serial_mul;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance: WIDTH=8, POLY=0x11B, DIGIT=1
    logic       sv = 1'b0, rr = 1'b1, ae = 1'b0;
    logic [7:0] a_i = '0, b_i = '0;
    logic       sr, rv;
    logic [7:0] res;

    // GF(4) instance
    logic       sv2 = 1'b0, rr2 = 1'b1;
    logic [1:0] a2 = '0, b2 = '0;
    logic       sr2, rv2;
    logic [1:0] res2;

    // DIGIT=2 instance
    logic       sv3 = 1'b0, rr3 = 1'b1;
    logic [7:0] a3 = '0, b3 = '0;
    logic       sr3, rv3;
    logic [7:0] res3;

    gf_serial_mul dut (
        .in_clock(clk), .in_reset(rst), .in_start_valid(sv), .out_start_ready(sr),
        .in_a(a_i), .in_b(b_i), .in_acc_en(ae), .out_result_valid(rv),
        .in_result_ready(rr), .out_result(res)
    );

    gf_serial_mul #(.WIDTH(2), .POLY(3'h7), .DIGIT(1)) dut_w2 (
        .in_clock(clk), .in_reset(rst), .in_start_valid(sv2), .out_start_ready(sr2),
        .in_a(a2), .in_b(b2), .in_acc_en(1'b0), .out_result_valid(rv2),
        .in_result_ready(rr2), .out_result(res2)
    );

    gf_serial_mul #(.WIDTH(8), .POLY(9'h11B), .DIGIT(2)) dut_d2 (
        .in_clock(clk), .in_reset(rst), .in_start_valid(sv3), .out_start_ready(sr3),
        .in_a(a3), .in_b(b3), .in_acc_en(1'b0), .out_result_valid(rv3),
        .in_result_ready(rr3), .out_result(res3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: LSB-first shift-and-add with xtime on a.
    function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= t;
            t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
        end
        return p;
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       acc_en;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] exp;
    } vec2_t;

    // Drives one op on the default instance at a negedge, waits for the result.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic acc,
                          input logic [7:0] exp, input logic ready_after, input string name);
        int lat;
        @(negedge clk);
        a_i = a; b_i = b; ae = acc; sv = 1'b1; rr = 1'b1;
        #1 check({name, " start_ready"}, 32'(sr), 32'd1);
        @(posedge clk);
        #1 sv = 1'b0; rr = ready_after;
        a_i = 8'hFF; b_i = 8'hFF;
        lat = 0;
        while (!rv && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd8);
        check({name, " result"}, 32'(res), 32'(exp));
    endtask

    vec_t  vecs[5];
    vec2_t vecs2[4];
    logic [7:0] prev;

    initial begin
        vecs[0] = '{8'h57, 8'h83, 1'b0, 8'hC1};
        vecs[1] = '{8'h53, 8'hCA, 1'b0, 8'h01};
        vecs[2] = '{8'h57, 8'h83, 1'b0, 8'hC1};
        vecs[3] = '{8'h57, 8'h13, 1'b1, 8'h3F};
        vecs[4] = '{8'h01, 8'hB7, 1'b1, 8'h88};
        vecs2[0] = '{2'd2, 2'd2, 2'd3};
        vecs2[1] = '{2'd3, 2'd3, 2'd2};
        vecs2[2] = '{2'd3, 2'd2, 2'd1};
        vecs2[3] = '{2'd0, 2'd3, 2'd0};

        // reset state, with start_valid asserted to show it is ignored
        sv = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid", 32'(rv), 32'd0);
        check("reset result", 32'(res), 32'd0);
        check("reset start_ready", 32'(sr), 32'd0);
        @(negedge clk);
        rst = 1'b0; sv = 1'b0;
        #1 check("idle start_ready", 32'(sr), 32'd1);

        // directed chain including accumulate, back-to-back via DONE
        for (int i = 0; i < 5; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].acc_en, vecs[i].exp, 1'b1, $sformatf("vec%0d", i));

        // backpressure
        @(negedge clk);
        rr = 1'b1; sv = 1'b0;
        run_op(8'h57, 8'h83, 1'b0, 8'hC1, 1'b0, "bp_first");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("bp valid", 32'(rv), 32'd1);
            check("bp result", 32'(res), 32'hC1);
            check("bp start_ready", 32'(sr), 32'd0);
        end
        run_op(8'h53, 8'hCA, 1'b0, 8'h01, 1'b1, "bp_restart");

        // reset during the 4th BUSY cycle
        @(negedge clk);
        a_i = 8'h57; b_i = 8'h83; ae = 1'b0; sv = 1'b1;
        @(posedge clk);
        #1 sv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; sv = 1'b1;
        @(posedge clk);
        #1;
        check("midrst valid", 32'(rv), 32'd0);
        check("midrst result", 32'(res), 32'd0);
        check("midrst start_ready", 32'(sr), 32'd0);
        @(negedge clk);
        rst = 1'b0; sv = 1'b0;
        #1 check("midrst released ready", 32'(sr), 32'd1);
        @(posedge clk);
        #1 check("midrst stays idle", 32'(rv), 32'd0);
        run_op(8'h02, 8'h80, 1'b0, 8'h1B, 1'b1, "post_rst");
        prev = 8'h1B;

        // GF(4) instance
        for (int i = 0; i < 4; i++) begin
            int lat;
            @(negedge clk);
            a2 = vecs2[i].a; b2 = vecs2[i].b; sv2 = 1'b1;
            #1 check($sformatf("w2_%0d start_ready", i), 32'(sr2), 32'd1);
            @(posedge clk);
            #1 sv2 = 1'b0;
            lat = 0;
            while (!rv2 && lat < 20) begin
                @(posedge clk);
                #1 lat++;
            end
            check($sformatf("w2_%0d latency", i), 32'(lat), 32'd2);
            check($sformatf("w2_%0d result", i), 32'(res2), 32'(vecs2[i].exp));
        end

        // DIGIT=2 instance
        for (int i = 0; i < 2; i++) begin
            int lat;
            @(negedge clk);
            a3 = vecs[i].a; b3 = vecs[i].b; sv3 = 1'b1;
            #1 check($sformatf("d2_%0d start_ready", i), 32'(sr3), 32'd1);
            @(posedge clk);
            #1 sv3 = 1'b0;
            lat = 0;
            while (!rv3 && lat < 20) begin
                @(posedge clk);
                #1 lat++;
            end
            check($sformatf("d2_%0d latency", i), 32'(lat), 32'd4);
            check($sformatf("d2_%0d result", i), 32'(res3), 32'(vecs[i].exp));
        end

        // random sweep with stalls and ignored start attempts while busy
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb, expv;
            logic       racc;
            int         lat;
            int         bad;
            ra = 8'($urandom); rb = 8'($urandom); racc = 1'($urandom);
            @(negedge clk);
            a_i = ra; b_i = rb; ae = racc; sv = 1'b1; rr = 1'b1;
            #1 check("rnd start_ready", 32'(sr), 32'd1);
            @(posedge clk);
            #1 sv = 1'b0;
            lat = 0; bad = 0;
            while (!rv && lat < 40) begin
                @(negedge clk);
                sv = 1'($urandom); a_i = 8'($urandom); b_i = 8'($urandom);
                ae = 1'($urandom); rr = 1'($urandom);
                #1 if (sr) bad++;
                @(posedge clk);
                #1 lat++;
            end
            sv = 1'b0; rr = 1'b0;
            expv = gf_mul8(ra, rb) ^ (racc ? prev : 8'h00);
            prev = expv;
            check("rnd no accept while busy", 32'(bad), 32'd0);
            check("rnd latency", 32'(lat), 32'd8);
            check("rnd result", 32'(res), 32'(expv));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                #1 check("rnd stall stable", 32'({rv, sr, res}), 32'({1'b1, 1'b0, expv}));
            end
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                rr = 1'b1;
                @(posedge clk);
                #1 check("rnd consumed", 32'({rv, res}), 32'({1'b0, expv}));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
